debounce_teclado_n: RTL and testbench
=====================================

# debounce_teclado_n

Parametrised multi-channel keypad debouncer for the microwave keypad path. It sits between the raw key lines and the digit encoder. Each channel produces one clean single-cycle press pulse per physical press. A registered priority stage then reports the winning key index to the encoder. This generalises the single-channel fixed-delay debounce counter in width, delay and re-arm behaviour.

## Interface
Parameters:
- `N_CANAIS`, default 10: number of key channels (digits 0–9).
- `N_ATRASO`, default 4: consecutive stable samples required to accept a press or a release; with a 10 ms `Clock` this gives 40 ms. Legal range is 2 or more.
- `N_REPETICAO`, default 25: auto-repeat period in cycles. Used only with `AUTO_REPEAT_EN`; legal range is 2 or more.

Ports:
- `Clock` input 1: single clock; all logic on posedge.
- `Clear` input 1: synchronous, active-high reset; it has priority over all other inputs.
- `tecla` input `N_CANAIS`: raw key levels, 1 = pressed. Inputs are already synchronised upstream.
- `estavel` output `N_CANAIS`: debounced level per channel.
- `pulso` output `N_CANAIS`: one-cycle press event per channel.
- `codigo` output `$clog2(N_CANAIS)`: index of the winning event.
- `valido` output 1: one-cycle qualifier for `codigo`.

## Operation
- Each channel runs an independent FSM with a saturating counter `cnt`. Counter width is `$clog2(max(N_ATRASO, N_REPETICAO) + 1)`. `cnt` never wraps.
- OCIOSA:
  - `tecla` = 1 → go to CONFIRMANDO with `cnt` = 1.
  - Otherwise stay, with `cnt` = 0.
- CONFIRMANDO:
  - `tecla` = 0 → return to OCIOSA with `cnt` = 0.
  - `tecla` = 1 and `cnt` = `N_ATRASO` − 1 → go to PRESSIONADA, assert `pulso[i]` and `estavel[i]`, and set `cnt` = 0.
  - Otherwise increment `cnt`.
- PRESSIONADA:
  - `tecla` = 0 → go to SOLTANDO with `cnt` = 1.
  - `tecla` = 1 → hold, with `cnt` = 0 (without `AUTO_REPEAT_EN`).
- SOLTANDO:
  - `tecla` = 1 → return to PRESSIONADA with `cnt` = 0. No new pulse is generated.
  - `tecla` = 0 and `cnt` = `N_ATRASO` − 1 → go to OCIOSA and clear `estavel[i]`.
  - Otherwise increment `cnt`.
- Exactly one `pulso` is produced per accepted press. A re-press is only accepted after `N_ATRASO` consecutive low samples.
- Priority stage:
  - On any cycle where `pulso` ≠ 0, the lowest set index wins.
  - The next cycle, `codigo` = that index and `valido` = 1.
  - Simultaneous events on higher channels are dropped, not queued.
- When `valido` = 0, `codigo` holds its last value.

## Timing
- All outputs are registered.
- Reset values: `estavel` = 0, `pulso` = 0, `codigo` = 0, `valido` = 0, every FSM in OCIOSA with `cnt` = 0.
- Press latency: if `tecla[i]` is first sampled high at edge k and stays high, `pulso[i]` and `estavel[i]` go high after edge k + `N_ATRASO` − 1. `pulso[i]` stays high exactly one cycle.
- `valido` and `codigo` follow `pulso` by one cycle, i.e. after edge k + `N_ATRASO`.
- Release latency: `estavel[i]` falls after edge j + `N_ATRASO` − 1, where j is the first low sample.
- `Clear` asserted mid-count or mid-press:
  - All outputs are 0 after that edge, and any pending `valido` is cancelled.
  - A key still held after `Clear` deasserts restarts from OCIOSA and produces a fresh pulse after `N_ATRASO` samples.
- A glitch shorter than `N_ATRASO` samples never produces a pulse.

## Configuration
- Macro `DEBOUNCE_AUTO_REPEAT_EN`.
- Defined:
  - In PRESSIONADA with `tecla` = 1, `cnt` increments.
  - On reaching `N_REPETICAO` − 1, `pulso[i]` is reasserted for one cycle and `cnt` = 0.
  - A held key therefore repeats every `N_REPETICAO` cycles after the first pulse.
  - SOLTANDO resets the repeat phase.
- Undefined: no repeat logic is generated; a held key yields exactly one pulse.

## Structure
- Shared package `teclado_pkg`:
  - FSM state enum: OCIOSA, CONFIRMANDO, PRESSIONADA, SOLTANDO.
  - Default constants `N_CANAIS_PADRAO` = 10 and `N_ATRASO_PADRAO` = 4.
  - Counter-width helper function.
- Sub-module `debounce_canal`: one channel (FSM + counter), instantiated `N_CANAIS` times in a generate loop.
- The top level contains only the generate loop and the priority/encoder register.

## Test plan
- `Clear` for 2 cycles with all `tecla` = 0 → all outputs 0.
- Reset-value check: `Clear` asserted with `tecla` = 10'h3FF → all outputs 0 and no pulse while `Clear` is high.
- `tecla[5]` high for 10 cycles, default parameters:
  - `pulso[5]` high only in the 4th cycle after the first high sample.
  - `valido` = 1 with `codigo` = 5 one cycle later.
  - No further pulse.
- Bounce pattern on `tecla[2]` of 1,1,1,0,1,1,1,1 → no pulse on the first burst; exactly one pulse on the 4th sample of the second burst.
- `tecla[3]` and `tecla[7]` rise on the same cycle → both `pulso` bits set together; `codigo` = 3, `valido` = 1 once; channel 7 is not reported.
- Press `tecla[1]`, release for 2 cycles, press again → no second pulse. Release for 4 cycles, press again → second pulse after 4 samples.
- With `DEBOUNCE_AUTO_REPEAT_EN` and `N_REPETICAO` = 5, `tecla[0]` held for 20 cycles → pulses at samples 4, 9, 14, 19.
- `Clear` pulsed mid-hold at cycle 6 of `tecla[4]` → `estavel[4]` drops. A new pulse appears 4 samples after `Clear` deasserts.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared types and constants for the multi-channel keypad debouncer.
package teclado_pkg;

    typedef enum logic [1:0] {
        OCIOSA,
        CONFIRMANDO,
        PRESSIONADA,
        SOLTANDO
    } estado_t;

    localparam int N_CANAIS_PADRAO = 10;
    localparam int N_ATRASO_PADRAO = 4;

    // Counter must hold the larger of the debounce and repeat limits without wrapping.
    function automatic int largura_cnt(input int atraso, input int repeticao);
        int maior;
        maior = (atraso > repeticao) ? atraso : repeticao;
        return $clog2(maior + 1);
    endfunction

endpackage

// File: rtl/debounce_canal.sv
// One keypad channel: debounce FSM with a saturating counter.
// Optional auto-repeat while held is built when DEBOUNCE_AUTO_REPEAT_EN is defined.
module debounce_canal
    import teclado_pkg::*;
#(
    parameter int N_ATRASO    = N_ATRASO_PADRAO,
    parameter int N_REPETICAO = 25
) (
    input  logic Clock,
    input  logic Clear,
    input  logic tecla,
    output logic estavel,
    output logic pulso
);

    localparam int CNT_W = largura_cnt(N_ATRASO, N_REPETICAO);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_ATRASO - 1);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] ULTIMO_REP = CNT_W'(N_REPETICAO - 1);
`endif

    estado_t          r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic             r_estavel;
    logic             r_pulso;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_estado  <= OCIOSA;
            r_cnt     <= '0;
            r_estavel <= 1'b0;
            r_pulso   <= 1'b0;
        end else begin
            r_pulso <= 1'b0;
            unique case (r_estado)
                OCIOSA: begin
                    if (tecla) begin
                        r_estado <= CONFIRMANDO;
                        r_cnt    <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                CONFIRMANDO: begin
                    if (!tecla) begin
                        r_estado <= OCIOSA;
                        r_cnt    <= '0;
                    end else if (r_cnt == ULTIMO) begin
                        r_estado  <= PRESSIONADA;
                        r_estavel <= 1'b1;
                        r_pulso   <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSIONADA: begin
                    if (!tecla) begin
                        r_estado <= SOLTANDO;
                        r_cnt    <= CNT_W'(1);
                    end else begin
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                        if (r_cnt == ULTIMO_REP) begin
                            r_pulso <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`else
                        r_cnt <= '0;
`endif
                    end
                end
                SOLTANDO: begin
                    // A bounce back high resumes the hold without a new press event.
                    if (tecla) begin
                        r_estado <= PRESSIONADA;
                        r_cnt    <= '0;
                    end else if (r_cnt == ULTIMO) begin
                        r_estado  <= OCIOSA;
                        r_estavel <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_estado <= OCIOSA;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign estavel = r_estavel;
    assign pulso   = r_pulso;

endmodule

// File: rtl/debounce_teclado_n.sv
// Multi-channel keypad debouncer with a registered lowest-index priority encoder.
// Auto-repeat is enabled per channel by defining DEBOUNCE_AUTO_REPEAT_EN.
module debounce_teclado_n
    import teclado_pkg::*;
#(
    parameter int N_CANAIS    = N_CANAIS_PADRAO,
    parameter int N_ATRASO    = N_ATRASO_PADRAO,
    parameter int N_REPETICAO = 25,
    localparam int COD_W      = $clog2(N_CANAIS)
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [N_CANAIS-1:0] tecla,
    output logic [N_CANAIS-1:0] estavel,
    output logic [N_CANAIS-1:0] pulso,
    output logic [COD_W-1:0]    codigo,
    output logic                valido
);

    logic [N_CANAIS-1:0] w_pulso;
    logic [COD_W-1:0]    w_indice;
    logic [COD_W-1:0]    r_codigo;
    logic                r_valido;

    for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
        debounce_canal #(
            .N_ATRASO   (N_ATRASO),
            .N_REPETICAO(N_REPETICAO)
        ) u_canal (
            .Clock  (Clock),
            .Clear  (Clear),
            .tecla  (tecla[g]),
            .estavel(estavel[g]),
            .pulso  (w_pulso[g])
        );
    end

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        w_indice = '0;
        for (int i = N_CANAIS - 1; i >= 0; i--) begin
            if (w_pulso[i]) begin
                w_indice = COD_W'(i);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_codigo <= '0;
            r_valido <= 1'b0;
        end else if (|w_pulso) begin
            r_codigo <= w_indice;
            r_valido <= 1'b1;
        end else begin
            r_valido <= 1'b0;
        end
    end

    assign pulso  = w_pulso;
    assign codigo = r_codigo;
    assign valido = r_valido;

endmodule

// File: tb/tb_debounce_teclado_n.sv
// Self-checking bench for debounce_teclado_n: directed steps plus random key activity
// compared against a run-length reference model.
module tb_debounce_teclado_n;

    localparam int N  = 10;
    localparam int NA = 4;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int NR = 5;
`else
    localparam int NR = 25;
`endif
    localparam int CW = $clog2(N);

    logic          Clock = 1'b0;
    logic          Clear = 1'b1;
    logic [N-1:0]  tecla = '0;
    logic [N-1:0]  estavel;
    logic [N-1:0]  pulso;
    logic [CW-1:0] codigo;
    logic          valido;

    always #5 Clock = ~Clock;

    debounce_teclado_n #(
        .N_CANAIS   (N),
        .N_ATRASO   (NA),
        .N_REPETICAO(NR)
    ) dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .tecla  (tecla),
        .estavel(estavel),
        .pulso  (pulso),
        .codigo (codigo),
        .valido (valido)
    );

    // Reference model: stable level, run of samples disagreeing with it, samples held since pulse.
    logic [N-1:0]  m_s;
    int            m_run  [N];
    int            m_hold [N];
    logic [N-1:0]  m_pulso;
    logic          m_valido;
    logic [CW-1:0] m_codigo;

    int n_checks = 0;
    int n_pass   = 0;
    int obs_p [N];
    int obs_valido = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model(input logic [N-1:0] t, input logic c);
        if (c) begin
            m_s = '0; m_pulso = '0; m_valido = 1'b0; m_codigo = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_hold[i] = 0;
            end
        end else begin
            m_valido = (m_pulso != '0);
            for (int i = N - 1; i >= 0; i--) begin
                if (m_pulso[i]) m_codigo = CW'(i);
            end
            for (int i = 0; i < N; i++) begin
                m_pulso[i] = 1'b0;
                if (t[i] != m_s[i]) begin
                    m_run[i]++;
                    m_hold[i] = 0;
                    if (m_run[i] == NA) begin
                        m_s[i]     = t[i];
                        m_run[i]   = 0;
                        m_pulso[i] = t[i];
                    end
                end else begin
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                    if (m_s[i] && m_run[i] == 0) begin
                        m_hold[i]++;
                        if (m_hold[i] == NR) begin
                            m_pulso[i] = 1'b1;
                            m_hold[i]  = 0;
                        end
                    end else begin
                        m_hold[i] = 0;
                    end
`endif
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] t, input logic c);
        tecla = t;
        Clear = c;
        @(posedge Clock);
        #1;
        model(t, c);
        for (int i = 0; i < N; i++) if (pulso[i] === 1'b1) obs_p[i]++;
        if (valido === 1'b1) obs_valido++;
        chk("estavel", 32'(estavel), 32'(m_s));
        chk("pulso",   32'(pulso),   32'(m_pulso));
        chk("valido",  32'(valido),  32'(m_valido));
        chk("codigo",  32'(codigo),  32'(m_codigo));
    endtask

    task automatic zero_obs();
        for (int i = 0; i < N; i++) obs_p[i] = 0;
        obs_valido = 0;
    endtask

    logic [N-1:0] lvl;

    initial begin
        m_s = '0; m_pulso = '0; m_valido = 1'b0; m_codigo = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_hold[i] = 0; obs_p[i] = 0;
        end

        // Reset with keys idle, then with every key pressed.
        step('0, 1'b1);
        step('0, 1'b1);
        chk("reset_idle_all", {estavel, pulso, codigo, valido}, '0);
        zero_obs();
        for (int k = 0; k < 5; k++) step('1, 1'b1);
        chk("reset_no_pulse", obs_p[0] + obs_p[9] + obs_valido, 0);
        step('0, 1'b0);
        for (int k = 0; k < 5; k++) step('0, 1'b0);

        // Single clean press on channel 5.
        zero_obs();
        for (int k = 1; k <= 10; k++) begin
            step(N'(1) << 5, 1'b0);
            if (k == 4) chk("p5_4th", 32'(pulso), 32'(N'(1) << 5));
            if (k == 5) chk("v5_code", {31'(codigo), valido}, {31'(5), 1'b1});
        end
        for (int k = 0; k < 6; k++) step('0, 1'b0);
        chk("p5_once", obs_p[5], 1);

        // Bounce on channel 2: 1,1,1,0,1,1,1,1.
        zero_obs();
        for (int k = 0; k < 3; k++) step(N'(1) << 2, 1'b0);
        step('0, 1'b0);
        chk("p2_burst1", obs_p[2], 0);
        for (int k = 0; k < 4; k++) step(N'(1) << 2, 1'b0);
        chk("p2_burst2_4th", 32'(pulso[2]), 1);
        for (int k = 0; k < 6; k++) step('0, 1'b0);
        chk("p2_once", obs_p[2], 1);

        // Channels 3 and 7 rise together: lowest index wins, 7 is dropped.
        zero_obs();
        for (int k = 0; k < 6; k++) step((N'(1) << 3) | (N'(1) << 7), 1'b0);
        for (int k = 0; k < 6; k++) step('0, 1'b0);
        chk("p3_p7_both", obs_p[3] + obs_p[7], 2);
        chk("valid_once", obs_valido, 1);
        chk("code_3", 32'(codigo), 3);

        // Short release does not re-arm; a full release does.
        zero_obs();
        for (int k = 0; k < 6; k++) step(N'(1) << 1, 1'b0);
        for (int k = 0; k < 2; k++) step('0, 1'b0);
        for (int k = 0; k < 6; k++) step(N'(1) << 1, 1'b0);
        chk("p1_no_repress", obs_p[1], 1);
        for (int k = 0; k < 4; k++) step('0, 1'b0);
        for (int k = 0; k < 6; k++) step(N'(1) << 1, 1'b0);
        for (int k = 0; k < 6; k++) step('0, 1'b0);
        chk("p1_repress", obs_p[1], 2);

        // Clear mid-hold on channel 4, key still held afterwards.
        zero_obs();
        for (int k = 0; k < 6; k++) step(N'(1) << 4, 1'b0);
        step(N'(1) << 4, 1'b1);
        chk("clr_estavel4", 32'(estavel[4]), 0);
        for (int k = 1; k <= 5; k++) begin
            step(N'(1) << 4, 1'b0);
            if (k == 4) chk("p4_after_clr", 32'(pulso[4]), 1);
        end
        for (int k = 0; k < 6; k++) step('0, 1'b0);
        chk("p4_twice", obs_p[4], 2);

`ifdef DEBOUNCE_AUTO_REPEAT_EN
        // Held key repeats every NR cycles after the first pulse.
        zero_obs();
        for (int k = 1; k <= 20; k++) begin
            step(N'(1), 1'b0);
            if (k == 4 || k == 9 || k == 14 || k == 19) chk("rep_pulse", 32'(pulso[0]), 1);
        end
        for (int k = 0; k < 6; k++) step('0, 1'b0);
        chk("rep_count", obs_p[0], 4);
`endif

        // Random key activity with occasional Clear.
        lvl = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) lvl[i] = ~lvl[i];
            end
            step(lvl, ($urandom_range(0, 79) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
